// File: rtl/global_defs.sv
// Shared types, timing constants and address-decode positions for the DRAM command scheduler.
// Latency: none, this file holds definitions only.
// Backpressure: none.
package global_defs;

  localparam int ADDRESS_WIDTH = 33;
  localparam int QUEUE_DEPTH   = 16;
  localparam int Q_COUNT_W     = $clog2(QUEUE_DEPTH + 1);

  // DRAM timing in core clock cycles
  localparam int tRCD   = 24;
  localparam int tCL    = 24;
  localparam int tCWL   = 20;
  localparam int tBURST = 4;
  localparam int tWR    = 20;
  localparam int tRAS   = 52;
  localparam int tRP    = 24;

  // Byte-address decode positions; bits below COLLO_LSB select bytes within a burst beat
  localparam int ROW_MSB   = 32;
  localparam int ROW_LSB   = 18;
  localparam int COLHI_MSB = 17;
  localparam int COLHI_LSB = 10;
  localparam int BANK_MSB  = 9;
  localparam int BANK_LSB  = 8;
  localparam int BG_MSB    = 7;
  localparam int BG_LSB    = 6;
  localparam int COLLO_MSB = 5;
  localparam int COLLO_LSB = 3;

  typedef enum logic [1:0] {READ, WRITE, IFETCH, NOP} parsed_op_t;
  typedef enum logic [2:0] {DESEL, ACT, RD, WR, PRE} dram_cmd_t;
  typedef enum logic [2:0] {
    IDLE, ACTIVATE, WAIT_RCD, COLUMN, WAIT_DATA, PRECHARGE, WAIT_RP
  } sched_states_t;

  typedef struct packed {
    parsed_op_t                 op;
    logic [ADDRESS_WIDTH-1:0]   addr;
  } req_t;

  typedef struct packed {
    logic [1:0]  bg;
    logic [1:0]  bank;
    logic [14:0] row;
    logic [10:0] col;
  } dram_fields_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Offset of PRE from ACT: row must stay open for tRAS and until the data burst (plus write recovery) is done
  localparam int RD_PRE_OFS = imax(tRAS, tRCD + tCL + tBURST);
  localparam int WR_PRE_OFS = imax(tRAS, tRCD + tCWL + tBURST + tWR);

  // A WAIT state exits on the cycle its counter reads 0, so a state of N cycles loads N-1.
  // Every wait spans the gap between two one-cycle command states, hence the extra -1.
  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] LOAD_RCD   = CNT_W'(tRCD - 2);
  localparam logic [CNT_W-1:0] LOAD_RDATA = CNT_W'(RD_PRE_OFS - tRCD - 2);
  localparam logic [CNT_W-1:0] LOAD_WDATA = CNT_W'(WR_PRE_OFS - tRCD - 2);
  localparam logic [CNT_W-1:0] LOAD_RP    = CNT_W'(tRP - 2);

  // Split a byte address into DRAM coordinates; column is {col_hi, col_lo}
  function automatic dram_fields_t decode_addr(input logic [ADDRESS_WIDTH-1:COLLO_LSB] a);
    dram_fields_t f;
    f.row  = a[ROW_MSB:ROW_LSB];
    f.bank = a[BANK_MSB:BANK_LSB];
    f.bg   = a[BG_MSB:BG_LSB];
    f.col  = {a[COLHI_MSB:COLHI_LSB], a[COLLO_MSB:COLLO_LSB]};
    return f;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// In-order request queue with head-of-queue lookahead and simultaneous push/pop.
// Latency: a push is visible in count and at the head one cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module req_fifo
  import global_defs::*;
#(
  parameter int  DEPTH = QUEUE_DEPTH,
  parameter type T     = req_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  T                             i_push_dat,
  input  logic                         i_pop,
  output T                             o_head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W_F = $clog2(DEPTH + 1);

  T                    r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W_F-1:0]  r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_full     = (r_count == CNT_W_F'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_do_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs
  assign w_do_push  = i_push && (!o_full || w_do_pop);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dram_scheduler.sv
// Closed-page, in-order DRAM command scheduler: queues parsed requests and issues ACT/RD|WR/PRE per request.
// Latency: ACT one cycle after the request reaches an idle queue head; column at +tRCD, PRE at +52 (read) / +68 (write).
// Backpressure: none upstream; requests arriving at a full queue are dropped and flagged in sticky overflow.
module dram_scheduler
  import global_defs::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       op_ready_s,
  input  parsed_op_t                 opcode,
  input  logic [ADDRESS_WIDTH-1:0]   address,
  output logic                       cmd_valid,
  output dram_cmd_t                  cmd,
  output logic [1:0]                 cmd_bg,
  output logic [1:0]                 cmd_bank,
  output logic [14:0]                cmd_row,
  output logic [10:0]                cmd_col,
  output logic [Q_COUNT_W-1:0]       q_count,
  output logic                       q_full,
  output logic                       overflow,
  output sched_states_t              state
);

  logic                   r_op_ready_q;
  logic                   r_overflow;
  sched_states_t          r_state;
  logic                   r_cmd_valid;
  dram_cmd_t              r_cmd;
  dram_fields_t           r_fields;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_is_write;

  logic                   w_rise;
  logic                   w_push;
  logic                   w_pop;
  req_t                   w_push_dat;
  req_t                   w_head;
  logic [Q_COUNT_W-1:0]   w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_unused_lsbs;

  assign w_rise     = op_ready_s && !r_op_ready_q;
  assign w_push     = w_rise && (opcode != NOP);
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_push_dat = '{op: opcode, addr: address};
  // Byte-within-beat bits travel with the request but never reach the DRAM
  assign w_unused_lsbs = ^w_head.addr[COLLO_LSB-1:0];

  req_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .T     (req_t)
  ) u_req_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Strobe history resets high so a strobe already asserted during reset is not seen as a new request
  always_ff @(posedge clk) begin
    if (!rst_n) r_op_ready_q <= 1'b1;
    else        r_op_ready_q <= op_ready_s;
  end

  // Sticky overflow: a push lost to a full queue with no pop to make room
  always_ff @(posedge clk) begin
    if (!rst_n)                            r_overflow <= 1'b0;
    else if (w_push && w_full && !w_pop)   r_overflow <= 1'b1;
  end

  // Scheduler FSM with registered command and address-field outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd       <= DESEL;
      r_fields    <= '0;
      r_cnt       <= '0;
      r_is_write  <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= DESEL;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state     <= ACTIVATE;
            r_cmd_valid <= 1'b1;
            r_cmd       <= ACT;
            r_fields    <= decode_addr(w_head.addr[ADDRESS_WIDTH-1:COLLO_LSB]);
            r_is_write  <= (w_head.op == WRITE);
          end
        end
        ACTIVATE: begin
          r_state <= WAIT_RCD;
          r_cnt   <= LOAD_RCD;
        end
        WAIT_RCD: begin
          if (r_cnt == '0) begin
            r_state     <= COLUMN;
            r_cmd_valid <= 1'b1;
            r_cmd       <= r_is_write ? WR : RD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        COLUMN: begin
          r_state <= WAIT_DATA;
          r_cnt   <= r_is_write ? LOAD_WDATA : LOAD_RDATA;
        end
        WAIT_DATA: begin
          if (r_cnt == '0) begin
            r_state     <= PRECHARGE;
            r_cmd_valid <= 1'b1;
            r_cmd       <= PRE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        PRECHARGE: begin
          r_state <= WAIT_RP;
          r_cnt   <= LOAD_RP;
        end
        WAIT_RP: begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd       = r_cmd;
  assign cmd_bg    = r_fields.bg;
  assign cmd_bank  = r_fields.bank;
  assign cmd_row   = r_fields.row;
  assign cmd_col   = r_fields.col;
  assign q_count   = w_count;
  assign q_full    = w_full;
  assign overflow  = r_overflow;
  assign state     = r_state;

endmodule

// File: doc/dram_scheduler.md
DRAM_SCHEDULER -- requirements
Module: dram_scheduler

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Port: clk  input  1  system clock; all state changes on posedge clk.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 Port: op_ready_s  input  1  parser strobe; a request is accepted only on its rising edge.
REQ-005 Port: opcode  input  parsed_op_t  READ, WRITE, IFETCH or NOP; sampled with op_ready_s.
REQ-006 Port: address  input  ADDRESS_WIDTH  byte address; sampled with op_ready_s.
REQ-007 Port: cmd_valid  output  1  high for exactly one cycle per issued DRAM command.
REQ-008 Port: cmd  output  dram_cmd_t  ACT, RD, WR or PRE; DESEL when cmd_valid is 0.
REQ-009 Port: cmd_bg / cmd_bank / cmd_row / cmd_col  output  2 / 2 / 15 / 11  decoded fields of the request in service.
REQ-010 Port: q_count  output  5  queue occupancy, 0..16.
REQ-011 Port: q_full  output  1  q_count == 16.
REQ-012 Port: overflow  output  1  sticky flag; set when an accepted request is dropped because the queue is full.
REQ-013 Port: state  output  sched_states_t  current scheduler state; for debug only.

Function
REQ-014 Rising edge = op_ready_s is 1 this cycle and its registered copy is 0; the edge SHALL be detected from the registered copy.
REQ-015 On a rising edge with opcode != NOP, the block SHALL push {opcode, address} into a 16-entry in-order queue.
- The entry is visible in q_count at the next edge.
- A NOP is discarded.
REQ-016 Push while full SHALL be dropped and SHALL set overflow, unless a pop occurs in the same cycle; in that case the push is accepted.
REQ-017 Address decode: row=[32:18], col_hi=[17:10], bank=[9:8], bg=[7:6], col_lo=[5:3]; cmd_col={col_hi,col_lo}; bits [2:0] are ignored.
REQ-018 IFETCH SHALL be scheduled identically to READ.
REQ-019 Scheduler states: IDLE, ACTIVATE, WAIT_RCD, COLUMN, WAIT_DATA, PRECHARGE, WAIT_RP.
- Policy: closed-page, one request at a time, strictly in queue order.
REQ-020 IDLE with a non-empty queue SHALL pop the head and enter ACTIVATE at the next edge.
REQ-021 Each of ACTIVATE, COLUMN and PRECHARGE SHALL last one cycle and drive cmd_valid=1 with ACT, RD/WR and PRE respectively.
- Address fields are held constant from ACTIVATE through PRECHARGE.
REQ-022 With ACT in cycle A, timing SHALL be:
- Column command at A+tRCD.
- Read PRE at A+max(tRAS, tRCD+tCL+tBURST) = A+52.
- Write PRE at A+max(tRAS, tRCD+tCWL+tBURST+tWR) = A+68.
REQ-023 WAIT_RP SHALL last until PRE+tRP, then return to IDLE.
- The next ACT, if the queue is non-empty, occurs at PRE+tRP+1.
REQ-024 A single down-counter SHALL be loaded on entry to each WAIT state; the block SHALL leave the state when the counter reaches 0.
REQ-025 Requests arriving mid-service SHALL queue without disturbing the active sequence.

Reset
REQ-026 While rst_n=0 at an edge, the block SHALL set:
- queue empty, q_count=0, q_full=0, overflow=0;
- state=IDLE, cmd_valid=0, cmd=DESEL;
- address field outputs = 0, counter = 0.
REQ-027 The registered copy of op_ready_s SHALL reset to 1, so a strobe held high through reset is not enqueued.
REQ-028 Reset asserted mid-sequence SHALL abort it immediately; no PRE is issued for the aborted request.

Structure
REQ-029 global_defs SHALL hold:
- dram_cmd_t and sched_states_t;
- QUEUE_DEPTH=16;
- tRCD=24, tCL=24, tCWL=20, tBURST=4, tWR=20, tRAS=52, tRP=24;
- the decode bit positions.
REQ-030 The queue SHALL be the sub-module req_fifo, parameterised by depth and entry type, with simultaneous push and pop supported.

Verification
REQ-031 Single READ 0x0_1234_5678: check ACT at A, RD at A+24, PRE at A+52, and decoded row/bg/bank/col.
REQ-032 Single WRITE: check WR at A+24 and PRE at A+68; with a second request queued, its ACT occurs at A+93.
REQ-033 Hold op_ready_s high for 5 cycles: exactly one entry is enqueued. A NOP strobe leaves q_count unchanged.
REQ-034 Push 17 requests while the first is in service: q_count reaches 16, q_full=1, overflow=0. Push 18 more: overflow=1 and stays high.
REQ-035 Push while full in the IDLE-pop cycle: the push is accepted, q_count is unchanged, overflow=0.
REQ-036 Assert rst_n=0 during WAIT_DATA with 3 requests queued: the next cycle shows all outputs at reset values and no PRE is issued.
